// File: rtl/seven_seg_scan_ctrl.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a time-multiplexed
// 4-digit seven-segment scan: one shared decoder, one-hot digit enables, leading-zero blanking.
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_value,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [3:0]  o_hex,
  output logic [3:0]  o_digit_en,
  output logic        o_blank,
  output logic        o_overflow,
  output logic        o_busy
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] REFRESH_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [15:0] MAX_VALUE = 16'd9999;
  localparam logic [3:0]  LAST_SHIFT = 4'd13;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [13:0]      bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [15:0]      bcd_adj;
  logic [3:0]       shift_cnt_q, shift_cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [15:0]      disp_bcd_q, disp_bcd_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [1:0]       scan_idx_q, scan_idx_d;
  logic [3:0]       digit_en_q, digit_en_d;

  // Add-3 correction on every BCD nibble that would reach 10 or more after the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    shift_cnt_d = shift_cnt_q;
    ovf_pend_d  = ovf_pend_q;
    disp_bcd_d  = disp_bcd_q;
    overflow_d  = overflow_q;
    refresh_d   = refresh_q;
    scan_idx_d  = scan_idx_q;
    digit_en_d  = digit_en_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          bin_d       = (i_value > MAX_VALUE) ? MAX_VALUE[13:0] : i_value[13:0];
          ovf_pend_d  = (i_value > MAX_VALUE);
          bcd_d       = 16'h0000;
          shift_cnt_d = 4'd0;
          state_d     = CONVERT;
          ready_d     = 1'b0;
          busy_d      = 1'b1;
        end
      end
      CONVERT: begin
        bcd_d       = {bcd_adj[14:0], bin_q[13]};
        bin_d       = {bin_q[12:0], 1'b0};
        shift_cnt_d = shift_cnt_q + 4'd1;
        if (shift_cnt_q == LAST_SHIFT) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        disp_bcd_d = bcd_q;
        overflow_d = ovf_pend_q;
        state_d    = IDLE;
        ready_d    = 1'b1;
        busy_d     = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Scan keeps running regardless of the converter state.
    if (refresh_q == REFRESH_MAX) begin
      refresh_d  = '0;
      scan_idx_d = scan_idx_q + 2'd1;
      digit_en_d = {digit_en_q[2:0], digit_en_q[3]};
    end else begin
      refresh_d = refresh_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      bin_q       <= '0;
      bcd_q       <= '0;
      shift_cnt_q <= '0;
      ovf_pend_q  <= 1'b0;
      disp_bcd_q  <= 16'h0000;
      overflow_q  <= 1'b0;
      refresh_q   <= '0;
      scan_idx_q  <= 2'd0;
      digit_en_q  <= 4'b0001;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      shift_cnt_q <= shift_cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      disp_bcd_q  <= disp_bcd_d;
      overflow_q  <= overflow_d;
      refresh_q   <= refresh_d;
      scan_idx_q  <= scan_idx_d;
      digit_en_q  <= digit_en_d;
    end
  end

  // Digit 0 is never blanked so a zero value still shows a single "0".
  always_comb begin
    o_hex = disp_bcd_q[4*scan_idx_q +: 4];
    case (scan_idx_q)
      2'd1:    o_blank = (disp_bcd_q[15:4] == 12'h000);
      2'd2:    o_blank = (disp_bcd_q[15:8] == 8'h00);
      2'd3:    o_blank = (disp_bcd_q[15:12] == 4'h0);
      default: o_blank = 1'b0;
    endcase
  end

  assign o_ready    = ready_q;
  assign o_busy     = busy_q;
  assign o_overflow = overflow_q;
  assign o_digit_en = digit_en_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: decimal-arithmetic reference model compared every cycle,
// plus directed literal checks and randomized traffic.
module tb_seven_seg_scan_ctrl;
  localparam int RD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'd0;
  logic        valid = 1'b0;
  logic        o_ready, o_blank, o_overflow, o_busy;
  logic [3:0]  o_hex, o_digit_en;

  int checks = 0;
  int errors = 0;

  seven_seg_scan_ctrl #(.REFRESH_DIV(RD)) dut (
    .i_clk(clk), .i_rst(rst), .i_value(value), .i_valid(valid),
    .o_ready(o_ready), .o_hex(o_hex), .o_digit_en(o_digit_en),
    .o_blank(o_blank), .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal value on display, pending conversion timer, scan tick count.
  int pow10 [4] = '{1, 10, 100, 1000};
  bit m_on = 0;
  int m_ticks, m_pending, m_since, m_pend_val, m_disp, m_idx;
  bit m_pend_ovf, m_ovf;

  always begin
    @(posedge clk);
    if (rst) begin
      m_on = 1; m_ticks = 0; m_pending = 0; m_disp = 0; m_ovf = 0;
    end else if (m_on) begin
      m_ticks++;
      if (m_pending != 0) begin
        m_since++;
        if (m_since == 15) begin
          m_disp = m_pend_val; m_ovf = m_pend_ovf; m_pending = 0;
        end
      end else if (valid) begin
        m_pending  = 1;
        m_since    = 0;
        m_pend_val = (value > 9999) ? 9999 : int'(value);
        m_pend_ovf = (value > 9999);
      end
    end
    #1;
    if (m_on) begin
      m_idx = (m_ticks / RD) % 4;
      check("m_ready", {31'd0, o_ready}, (m_pending == 0) ? 32'd1 : 32'd0);
      check("m_busy", {31'd0, o_busy}, (m_pending != 0) ? 32'd1 : 32'd0);
      check("m_ovf", {31'd0, o_overflow}, {31'd0, m_ovf});
      check("m_digit_en", {28'd0, o_digit_en}, 32'd1 << m_idx);
      check("m_hex", {28'd0, o_hex}, (m_disp / pow10[m_idx]) % 10);
      check("m_blank", {31'd0, o_blank}, (m_idx > 0 && m_disp < pow10[m_idx]) ? 32'd1 : 32'd0);
    end
  end

  task automatic wait_digit(input logic [3:0] en);
    int n = 0;
    while (o_digit_en !== en && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("digit_timeout", {28'd0, o_digit_en}, {28'd0, en});
  endtask

  task automatic show(input logic [3:0] en, input logic [3:0] hex, input logic blank);
    wait_digit(en);
    check("show_hex", {28'd0, o_hex}, {28'd0, hex});
    check("show_blank", {31'd0, o_blank}, {31'd0, blank});
  endtask

  // Offer v, wait for the accept edge, then return edges until o_ready is high again.
  task automatic send(input logic [15:0] v, output int lat);
    int w = 0;
    @(negedge clk);
    rst = 1'b0; value = v; valid = 1'b1;
    while (!o_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) check("accept_timeout", {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    check("ready_low_after_accept", {31'd0, o_ready}, 32'd0);
    lat = 0;
    while (!o_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    $display("txn value=%0d ready_latency=%0d", v, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, k;
    logic [15:0] v;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_digit_en", {28'd0, o_digit_en}, 32'd1);
    check("rst_hex", {28'd0, o_hex}, 32'd0);
    check("rst_blank", {31'd0, o_blank}, 32'd0);
    show(4'b0010, 4'd0, 1'b1);
    show(4'b0100, 4'd0, 1'b1);
    show(4'b1000, 4'd0, 1'b1);

    send(16'd1234, lat);
    check("latency_1234", lat, 32'd15);
    show(4'b0001, 4'd4, 1'b0);
    show(4'b0010, 4'd3, 1'b0);
    show(4'b0100, 4'd2, 1'b0);
    show(4'b1000, 4'd1, 1'b0);
    check("ovf_1234", {31'd0, o_overflow}, 32'd0);

    send(16'd9, lat);
    show(4'b0001, 4'd9, 1'b0);
    show(4'b0010, 4'd0, 1'b1);
    show(4'b1000, 4'd0, 1'b1);

    send(16'd105, lat);
    show(4'b0010, 4'd0, 1'b0);
    show(4'b0100, 4'd1, 1'b0);
    show(4'b1000, 4'd0, 1'b1);

    send(16'hFFFF, lat);
    check("ovf_ffff", {31'd0, o_overflow}, 32'd1);
    show(4'b0001, 4'd9, 1'b0);
    show(4'b1000, 4'd9, 1'b0);

    send(16'd42, lat);
    check("ovf_42", {31'd0, o_overflow}, 32'd0);
    show(4'b0010, 4'd4, 1'b0);

    // Valid held high: 5 then 7 offered while busy; accepts must be 16 cycles apart.
    @(negedge clk);
    value = 16'd5; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    value = 16'd7;
    k = 0;
    while (!o_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("accept_spacing", k + 1, 32'd16);
    $display("txn value=5 then 7 spacing=%0d", k + 1);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    k = 0;
    while (!o_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    show(4'b0001, 4'd7, 1'b0);

    // Reset sampled at accept+7 aborts the 8888 conversion.
    @(negedge clk);
    value = 16'd8888; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {31'd0, o_ready}, 32'd1);
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_digit_en", {28'd0, o_digit_en}, 32'd1);
    check("abort_hex", {28'd0, o_hex}, 32'd0);
    $display("txn value=8888 aborted by reset");
    repeat (20) @(negedge clk);
    show(4'b0001, 4'd0, 1'b0);
    show(4'b1000, 4'd0, 1'b1);
    check("abort_ovf", {31'd0, o_overflow}, 32'd0);

    // Randomized traffic: noisy valid while busy, occasional resets, then a clean send.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 20)) begin
        @(negedge clk);
        valid = 1'($urandom_range(0, 1));
        value = 16'($urandom);
        rst   = ($urandom_range(0, 99) == 0);
      end
      v = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9999));
      send(v, lat);
      check("rand_latency", lat, 32'd15);
    end

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Converts a binary value into four BCD digits with a sequential shift-add-3 (double-dabble) conversion.
- Time-multiplexes one shared SevenHexDecoder instance across a 4-digit common-enable display.
- Sits between the value producer (counter/caller logic) and the decoder. o_hex feeds the decoder's i_hex; o_digit_en drives the digit enables; o_blank forces the segment bus dark.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays enabled. Legal range >= 1.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_value  in  16  binary value to display
- i_valid  in  1  producer offers i_value
- o_ready  out  1  block can accept a value (IDLE)
- o_hex  out  4  BCD digit for the currently scanned position, to decoder i_hex
- o_digit_en  out  4  one-hot active-high digit enable; bit k = digit k, digit 0 = least significant
- o_blank  out  1  current digit is a leading zero; driver forces all segments dark
- o_overflow  out  1  displayed value was clamped
- o_busy  out  1  conversion in progress

Behaviour:
- One clock (i_clk). Reset is synchronous and active-high (i_rst). All state changes on the rising edge of i_clk.
- Reset values:
  - state IDLE, o_ready 1, o_busy 0
  - disp_bcd 16'h0000, o_overflow 0
  - scan_idx 0, o_digit_en 4'b0001, refresh count 0
  - o_hex 0, o_blank 0
- Reset mid-conversion aborts the conversion; no partial result is committed.
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE: o_ready=1. Accept occurs at the edge where i_valid && o_ready. On accept:
    - load the working binary register with min(i_value, 9999)
    - set the pending overflow flag to (i_value > 9999)
    - clear the working BCD register and shift count
    - go to CONVERT
  - CONVERT: o_ready=0, o_busy=1. Each cycle, add 3 to every working BCD nibble >= 5, then shift {bcd, bin} left by 1. Exactly 14 shifts, count 0..13. After the 14th shift, go to COMMIT.
  - COMMIT: o_busy=1, o_ready=0. At this edge disp_bcd <= working BCD and o_overflow <= pending flag. Next state IDLE.
- Latency, with accept at edge E:
  - shifts occur at edges E+1..E+14
  - commit at edge E+15
  - o_ready is high again from edge E+15
  - minimum spacing between accepts is 16 cycles
- i_valid while not ready is ignored; nothing is latched. The producer holds i_valid until accepted.
- Scan:
  - Runs continuously and independently of the FSM, including during conversion. It always shows the last committed disp_bcd.
  - The refresh counter counts 0..REFRESH_DIV-1.
  - At wrap: counter -> 0, scan_idx <= scan_idx+1 mod 4, o_digit_en rotates left (4'b1000 -> 4'b0001).
  - REFRESH_DIV=1 advances the digit every cycle.
- o_hex and o_blank are combinational from disp_bcd and scan_idx:
  - o_hex = disp_bcd[4*scan_idx +: 4]
  - o_blank = 1 when scan_idx > 0 and nibbles scan_idx..3 are all zero
  - digit 0 is never blanked, so value 0 shows a single "0"
  - both change in the same cycle as a commit or a scan step
- o_digit_en is always exactly one-hot and never 0.
- o_hex is always in 0..9, so the decoder's unlisted codes are never driven.

Test Plan:
- Reset, REFRESH_DIV=2 -> o_ready=1, o_digit_en=0001, o_hex=0, o_blank=0. Digits 1..3 show o_blank=1 while scanned.
- Accept i_value=1234 at edge E -> o_ready low E..E+14, high at E+15. disp_bcd=16'h1234. Scan yields o_hex 4,3,2,1 on enables 0001,0010,0100,1000, all unblanked; o_overflow=0.
- i_value=9 -> digit0 o_hex=9, o_blank=0; digits 1..3 o_blank=1. i_value=105 -> digit2 o_hex=1, digit1 o_hex=0 unblanked, digit3 blanked.
- i_value=16'hFFFF -> display 9999, o_overflow=1. A following i_value=42 clears o_overflow at its commit.
- i_valid held high continuously with 5 then 7 -> accepts exactly 16 cycles apart. Display 0005, then 0007; the value offered while busy is not latched.
- i_rst asserted at edge E+7 of a conversion of 8888 -> next cycle IDLE, o_ready=1, display 0, o_digit_en=0001, no commit of 8888.
